// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings shared by the ALU, its issue stage and their benches
package alu_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
endpackage

// File: rtl/alu_res_fifo.sv
// alu_res_fifo: sync FIFO (push/din in, pop in, full/empty out) with a registered head on dout
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int PW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd, rd_n;
  assign empty = wr == rd;
  assign full = (wr[PW-1] != rd[PW-1]) && (wr[PW-2:0] == rd[PW-2:0]);
  assign rd_n = rd + PW'(pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      dout <= '0;
    end else begin
      wr <= wr + PW'(push);
      rd <= rd_n;
      if (push || wr != rd_n) dout <= (wr == rd_n) ? din : mem[rd_n[PW-2:0]];
    end
  always_ff @(posedge clk)
    if (push) mem[wr[PW-2:0]] <= din;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registers cmd_* commands onto alu_*, queues {alu_sel, alu_z} and serves them on res_*
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int RESW  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_a,
  input  logic [OPW-1:0]  cmd_b,
  input  logic [1:0]      cmd_sel,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [1:0]      alu_sel,
  input  logic [RESW-1:0] alu_z,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RESW-1:0] res_data,
  output logic [1:0]      res_sel,
  output logic [7:0]      issue_cnt
);
  logic op_vld, push, pop, accept, full, empty;
  logic [RESW+1:0] head;
  assign res_valid = !empty;
  assign pop = res_valid & res_ready;
  assign push = op_vld & (!full | pop);
  assign cmd_ready = !op_vld | push;
  assign accept = cmd_valid & cmd_ready;
  assign {res_sel, res_data} = head;
  alu_res_fifo #(.WIDTH(RESW + 2), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({alu_sel, alu_z}),
    .full(full),
    .empty(empty),
    .dout(head)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      op_vld <= 1'b0;
      issue_cnt <= '0;
    end else begin
      if (accept) begin
        alu_a <= cmd_a;
        alu_b <= cmd_b;
        alu_sel <= cmd_sel;
      end
      op_vld <= accept | (op_vld & !push);
      issue_cnt <= issue_cnt + 8'(accept);
    end
endmodule
